traffic_phase_scheduler: RTL and testbench
==========================================

// Module: traffic_phase_scheduler
// PURPOSE
//  Demand-actuated phase controller for the NS/EW intersection. Sequences green,
//  yellow and all-red phases from car sensors, latched pedestrian requests and
//  emergency preemption. Drives the 2-bit light codes (00 red, 01 green, 10 yellow)
//  that feed the LED decode, plus walk outputs. Timing advances on a 1-tick-per-second
//  enable from the prescaler.
// PARAMETERS
//  CNT_W        6   width of phase elapsed counter (saturating)
//  MIN_GREEN    5   minimum green, ticks
//  MAX_GREEN   20   green limit while own-side car holds and opposing demand waits
//  YELLOW_TIME  3   yellow duration, ticks
//  ALL_RED_TIME 1   all-red clearance, ticks
//  WALK_TIME    4   walk duration at start of served green, ticks
//  Constraints: all >=1; MAX_GREEN>=MIN_GREEN; all < 2**CNT_W
// PORTS
//  clk        in   1  system clock
//  reset      in   1  synchronous, active-low reset
//  tick       in   1  1-cycle timing enable; all phase timing counts tick cycles only
//  ns_car     in   1  NS vehicle present (level)
//  ew_car     in   1  EW vehicle present (level)
//  ped_ns_req in   1  pedestrian request for crossing served in NS green (any-cycle pulse)
//  ped_ew_req in   1  pedestrian request for crossing served in EW green
//  preempt    in   1  emergency preemption active (level)
//  preempt_ew in   1  preemption target: 0=NS, 1=EW
//  ns_light   out  2  NS light code
//  ew_light   out  2  EW light code
//  walk_ns    out  1  NS-parallel walk
//  walk_ew    out  1  EW-parallel walk
//  phase      out  3  current state encoding (debug)
//  preempt_on out  1  preempt held and target direction green
// BEHAVIOUR
//  Reset (reset==0 at posedge clk; applies mid-phase, overrides tick): state=INIT_RED,
//   ns_light=ew_light=00, walk_*=0, preempt_on=0, elapsed=0, ped pendings cleared.
//  States: INIT_RED(0) NS_GRN(1) NS_YEL(2) RED_A(3) EW_GRN(4) EW_YEL(5) RED_B(6).
//  Moore outputs registered with state; change on the same edge as the state change.
//   NS_GRN: ns=01, ew=00. NS_YEL: ns=10, ew=00. EW_GRN/EW_YEL mirror. Others: both 00.
//  elapsed cleared on state entry, +1 per tick in state, saturates. e = elapsed+1 on a tick.
//  State changes only on tick cycles. Fixed states leave when e == duration:
//   INIT_RED,RED_A,RED_B: ALL_RED_TIME; NS_YEL,EW_YEL: YELLOW_TIME.
//  Sequence: INIT_RED->NS_GRN->NS_YEL->RED_A->EW_GRN->EW_YEL->RED_B->NS_GRN.
//  Ped requests latch into ped_*_pend on any cycle (incl. in own green). Pending is
//   cleared on the edge entering own green and recorded as walk-served for that green.
//  walk_x=1 from entry of x green while served and elapsed<WALK_TIME; else 0.
//  Green x exits to its yellow on a tick when, with opp = opposing car | opposing pend:
//   e >= ming && opp && (!own_car || e >= MAX_GREEN);
//   ming = served ? max(MIN_GREEN,WALK_TIME) : MIN_GREEN.
//   No opposing demand: rest in green indefinitely.
//  Preemption, sampled on tick:
//   preempt && target != current green: exit to yellow on that tick, ignoring min/walk;
//    walk drops with state.
//   preempt && target == current green: hold green, exit rule ignored; preempt_on=1.
//   RED_A/RED_B/INIT_RED exit: go to target green if preempt, else normal sequence.
//   Yellow and all-red are never shortened.
//  Simultaneous ped request and own-green entry: request stays pending for next cycle.
// TESTING (tick tied high unless stated; cycle 0 = first edge with reset=1)
//  1 No inputs -> INIT_RED 1 cycle, NS_GRN from cycle 1, stays NS green for 100 cycles.
//  2 ew_car=1 constant -> NS_GRN 5, NS_YEL 3, RED_A 1, EW_GRN; rests EW since ns_car=0.
//  3 ns_car=ew_car=1 -> NS green exactly 20 cycles, then yellow; EW green also 20.
//  4 ped_ew_req pulse during NS_GRN -> EW_GRN entered, walk_ew high 4 cycles, pend cleared.
//  5 In EW_GRN elapsed=1, preempt=1, preempt_ew=0 -> EW_YEL next tick, 3 yellow, 1 red,
//    NS_GRN with preempt_on=1 held despite ew_car=1; released -> normal exit rule.
//  6 reset=0 one cycle mid NS_YEL -> both lights 00, phase=0; tick=0 stalls all phases.

Source files
------------

// File: rtl/traffic_phase_scheduler.sv
// traffic_phase_scheduler
//   Demand-actuated phase controller for a two-way (NS/EW) intersection.
//   Sequences green, yellow and all-red phases from car sensors, latched
//   pedestrian requests and emergency preemption. All timing is counted in
//   cycles where tick is high.
//
// Ports
//   clk         system clock
//   reset       synchronous, active-low reset
//   tick        1-cycle timing enable (one per second from the prescaler)
//   ns_car      NS vehicle present (level)
//   ew_car      EW vehicle present (level)
//   ped_ns_req  pedestrian request served during NS green (pulse)
//   ped_ew_req  pedestrian request served during EW green (pulse)
//   preempt     emergency preemption active (level)
//   preempt_ew  preemption target: 0 = NS, 1 = EW
//   ns_light    NS light code (00 red, 01 green, 10 yellow)
//   ew_light    EW light code
//   walk_ns     NS-parallel walk
//   walk_ew     EW-parallel walk
//   phase       current state encoding (debug)
//   preempt_on  preemption held with its target direction green
module traffic_phase_scheduler #(
  parameter int unsigned CNT_W        = 6,
  parameter int unsigned MIN_GREEN    = 5,
  parameter int unsigned MAX_GREEN    = 20,
  parameter int unsigned YELLOW_TIME  = 3,
  parameter int unsigned ALL_RED_TIME = 1,
  parameter int unsigned WALK_TIME    = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       ns_car,
  input  logic       ew_car,
  input  logic       ped_ns_req,
  input  logic       ped_ew_req,
  input  logic       preempt,
  input  logic       preempt_ew,
  output logic [1:0] ns_light,
  output logic [1:0] ew_light,
  output logic       walk_ns,
  output logic       walk_ew,
  output logic [2:0] phase,
  output logic       preempt_on
);

  typedef enum logic [2:0] {
    INIT_RED = 3'd0,
    NS_GRN   = 3'd1,
    NS_YEL   = 3'd2,
    RED_A    = 3'd3,
    EW_GRN   = 3'd4,
    EW_YEL   = 3'd5,
    RED_B    = 3'd6
  } state_t;

  localparam logic [1:0] LT_RED    = 2'b00;
  localparam logic [1:0] LT_GREEN  = 2'b01;
  localparam logic [1:0] LT_YELLOW = 2'b10;

  // A served walk must run to completion before the green may end normally.
  localparam int unsigned SERVED_MIN = (WALK_TIME > MIN_GREEN) ? WALK_TIME : MIN_GREEN;

  // Thresholds are compared against e = elapsed + 1, which needs one extra bit.
  localparam logic [CNT_W:0]   K_ONE     = (CNT_W+1)'(1);
  localparam logic [CNT_W:0]   K_MIN     = (CNT_W+1)'(MIN_GREEN);
  localparam logic [CNT_W:0]   K_SRV_MIN = (CNT_W+1)'(SERVED_MIN);
  localparam logic [CNT_W:0]   K_MAX     = (CNT_W+1)'(MAX_GREEN);
  localparam logic [CNT_W:0]   K_YEL     = (CNT_W+1)'(YELLOW_TIME);
  localparam logic [CNT_W:0]   K_ALL_RED = (CNT_W+1)'(ALL_RED_TIME);
  localparam logic [CNT_W-1:0] K_WALK    = CNT_W'(WALK_TIME);
  localparam logic [CNT_W-1:0] K_INC     = CNT_W'(1);

  state_t           state;
  state_t           nxt;
  state_t           pre_tgt;
  logic [CNT_W-1:0] elapsed;
  logic [CNT_W-1:0] elapsed_nxt;
  logic [CNT_W:0]   e;
  logic             ped_ns_pend;
  logic             ped_ew_pend;
  logic             ns_served;
  logic             ew_served;
  logic             ped_ns_pend_nxt;
  logic             ped_ew_pend_nxt;
  logic             ns_served_nxt;
  logic             ew_served_nxt;
  logic             in_ew;
  logic             own_car;
  logic             opp_demand;
  logic             served;
  logic [CNT_W:0]   ming;
  logic             normal_exit;
  logic             green_exit;

  assign phase = state;

  // Green exit decision, evaluated for whichever green is current.
  always_comb begin
    in_ew       = (state == EW_GRN);
    own_car     = in_ew ? ew_car : ns_car;
    opp_demand  = in_ew ? (ns_car | ped_ns_pend) : (ew_car | ped_ew_pend);
    served      = in_ew ? ew_served : ns_served;
    ming        = served ? K_SRV_MIN : K_MIN;
    e           = {1'b0, elapsed} + K_ONE;
    pre_tgt     = preempt_ew ? EW_GRN : NS_GRN;
    normal_exit = (e >= ming) && opp_demand && (!own_car || (e >= K_MAX));
    // Preemption overrides the normal rule entirely: leave at once if the
    // target is the other side, never leave while the target is this side.
    green_exit  = preempt ? (pre_tgt != state) : normal_exit;
  end

  always_comb begin
    nxt = state;
    if (tick) begin
      unique case (state)
        INIT_RED, RED_A, RED_B: begin
          if (e == K_ALL_RED) begin
            if (preempt)             nxt = pre_tgt;
            else if (state == RED_A) nxt = EW_GRN;
            else                     nxt = NS_GRN;
          end
        end
        NS_YEL:  if (e == K_YEL) nxt = RED_A;
        EW_YEL:  if (e == K_YEL) nxt = RED_B;
        NS_GRN:  if (green_exit) nxt = NS_YEL;
        EW_GRN:  if (green_exit) nxt = EW_YEL;
        default: nxt = INIT_RED;
      endcase
    end
  end

  // Elapsed counter and pedestrian bookkeeping for the upcoming state.
  always_comb begin
    if (nxt != state)
      elapsed_nxt = '0;
    else if (tick && (elapsed != '1))
      elapsed_nxt = elapsed + K_INC;
    else
      elapsed_nxt = elapsed;

    ns_served_nxt   = ns_served;
    ew_served_nxt   = ew_served;
    ped_ns_pend_nxt = ped_ns_pend | ped_ns_req;
    ped_ew_pend_nxt = ped_ew_pend | ped_ew_req;

    // On entry to a green the old pending request is consumed; a request
    // arriving on that same cycle is kept for the following green.
    if ((nxt == NS_GRN) && (state != NS_GRN)) begin
      ns_served_nxt   = ped_ns_pend;
      ped_ns_pend_nxt = ped_ns_req;
    end
    if ((nxt == EW_GRN) && (state != EW_GRN)) begin
      ew_served_nxt   = ped_ew_pend;
      ped_ew_pend_nxt = ped_ew_req;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= INIT_RED;
      elapsed     <= '0;
      ped_ns_pend <= 1'b0;
      ped_ew_pend <= 1'b0;
      ns_served   <= 1'b0;
      ew_served   <= 1'b0;
      ns_light    <= LT_RED;
      ew_light    <= LT_RED;
      walk_ns     <= 1'b0;
      walk_ew     <= 1'b0;
      preempt_on  <= 1'b0;
    end else begin
      state       <= nxt;
      elapsed     <= elapsed_nxt;
      ped_ns_pend <= ped_ns_pend_nxt;
      ped_ew_pend <= ped_ew_pend_nxt;
      ns_served   <= ns_served_nxt;
      ew_served   <= ew_served_nxt;

      unique case (nxt)
        NS_GRN:  begin ns_light <= LT_GREEN;  ew_light <= LT_RED;    end
        NS_YEL:  begin ns_light <= LT_YELLOW; ew_light <= LT_RED;    end
        EW_GRN:  begin ns_light <= LT_RED;    ew_light <= LT_GREEN;  end
        EW_YEL:  begin ns_light <= LT_RED;    ew_light <= LT_YELLOW; end
        default: begin ns_light <= LT_RED;    ew_light <= LT_RED;    end
      endcase

      walk_ns    <= (nxt == NS_GRN) && ns_served_nxt && (elapsed_nxt < K_WALK);
      walk_ew    <= (nxt == EW_GRN) && ew_served_nxt && (elapsed_nxt < K_WALK);
      preempt_on <= preempt && (nxt == pre_tgt);
    end
  end

endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// tb_traffic_phase_scheduler
//   Scoreboard bench: the stimulus process drives one input vector per cycle,
//   advances a behavioural reference of the intersection and queues the
//   expected outputs; the monitor compares just after each rising edge.
module tb_traffic_phase_scheduler;

  localparam int CNT_W        = 6;
  localparam int MIN_GREEN    = 5;
  localparam int MAX_GREEN    = 20;
  localparam int YELLOW_TIME  = 3;
  localparam int ALL_RED_TIME = 1;
  localparam int WALK_TIME    = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       tick = 1'b1;
  logic       ns_car = 1'b0;
  logic       ew_car = 1'b0;
  logic       ped_ns_req = 1'b0;
  logic       ped_ew_req = 1'b0;
  logic       preempt = 1'b0;
  logic       preempt_ew = 1'b0;
  logic [1:0] ns_light;
  logic [1:0] ew_light;
  logic       walk_ns;
  logic       walk_ew;
  logic [2:0] phase;
  logic       preempt_on;

  traffic_phase_scheduler #(
    .CNT_W(CNT_W), .MIN_GREEN(MIN_GREEN), .MAX_GREEN(MAX_GREEN),
    .YELLOW_TIME(YELLOW_TIME), .ALL_RED_TIME(ALL_RED_TIME), .WALK_TIME(WALK_TIME)
  ) dut (
    .clk(clk), .reset(reset), .tick(tick), .ns_car(ns_car), .ew_car(ew_car),
    .ped_ns_req(ped_ns_req), .ped_ew_req(ped_ew_req), .preempt(preempt),
    .preempt_ew(preempt_ew), .ns_light(ns_light), .ew_light(ew_light),
    .walk_ns(walk_ns), .walk_ew(walk_ew), .phase(phase), .preempt_on(preempt_on)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0] ns;
    logic [1:0] ew;
    logic       wns;
    logic       wew;
    logic [2:0] ph;
    logic       pon;
  } obs_t;

  obs_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  // Reference state: phase index in the fixed ring, ticks spent in it,
  // pedestrian pendings and whether the current green is serving a walk.
  int m_ph = 0;
  int m_t  = 0;
  bit m_pns = 0, m_pew = 0, m_sns = 0, m_sew = 0;

  function automatic int fixed_len(input int p);
    if (p == 2 || p == 5) return YELLOW_TIME;
    return ALL_RED_TIME;
  endfunction

  function automatic int ring_next(input int p);
    int ring[7] = '{1, 2, 3, 4, 5, 6, 1};
    return ring[p];
  endfunction

  task automatic cycle(input bit rst, input bit tk, input bit nc, input bit ec,
                       input bit pn, input bit pw, input bit pr, input bit pe);
    int   nph;
    int   tgt;
    int   e;
    int   ming;
    bit   ns_side, own, opp, srv;
    obs_t x;
    @(negedge clk);
    reset = rst; tick = tk; ns_car = nc; ew_car = ec;
    ped_ns_req = pn; ped_ew_req = pw; preempt = pr; preempt_ew = pe;
    cyc++;
    tgt = pe ? 4 : 1;
    if (!rst) begin
      m_ph = 0; m_t = 0; m_pns = 0; m_pew = 0; m_sns = 0; m_sew = 0;
      x = '0;
    end else begin
      nph = m_ph;
      if (tk) begin
        e = m_t + 1;
        if (m_ph == 1 || m_ph == 4) begin
          ns_side = (m_ph == 1);
          own  = ns_side ? nc : ec;
          opp  = ns_side ? (ec || m_pew) : (nc || m_pns);
          srv  = ns_side ? m_sns : m_sew;
          ming = (srv && WALK_TIME > MIN_GREEN) ? WALK_TIME : MIN_GREEN;
          if (pr) begin
            if (tgt != m_ph) nph = m_ph + 1;
          end else if (e >= ming && opp && (!own || e >= MAX_GREEN)) begin
            nph = m_ph + 1;
          end
        end else if (e == fixed_len(m_ph)) begin
          if (pr && (m_ph == 0 || m_ph == 3 || m_ph == 6)) nph = tgt;
          else nph = ring_next(m_ph);
        end
      end
      if (nph == 1 && m_ph != 1) begin m_sns = m_pns; m_pns = pn; end
      else m_pns = m_pns | pn;
      if (nph == 4 && m_ph != 4) begin m_sew = m_pew; m_pew = pw; end
      else m_pew = m_pew | pw;
      if (nph != m_ph) m_t = 0;
      else if (tk) m_t = m_t + 1;
      m_ph = nph;
      x.ns  = (m_ph == 1) ? 2'b01 : (m_ph == 2) ? 2'b10 : 2'b00;
      x.ew  = (m_ph == 4) ? 2'b01 : (m_ph == 5) ? 2'b10 : 2'b00;
      x.wns = (m_ph == 1) && m_sns && (m_t < WALK_TIME);
      x.wew = (m_ph == 4) && m_sew && (m_t < WALK_TIME);
      x.ph  = 3'(m_ph);
      x.pon = pr && (m_ph == tgt);
    end
    exp_q.push_back(x);
  endtask

  initial begin : monitor
    obs_t exp_v;
    obs_t got;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        exp_v = exp_q.pop_front();
        got = {ns_light, ew_light, walk_ns, walk_ew, phase, preempt_on};
        checks++;
        if (got !== exp_v) begin
          errors++;
          $display("FAIL outputs cyc=%0d got ns=%b ew=%b wns=%b wew=%b ph=%0d pon=%b exp ns=%b ew=%b wns=%b wew=%b ph=%0d pon=%b",
                   cyc, got.ns, got.ew, got.wns, got.wew, got.ph, got.pon,
                   exp_v.ns, exp_v.ew, exp_v.wns, exp_v.wew, exp_v.ph, exp_v.pon);
        end
      end
    end
  end

  task automatic do_reset();
    repeat (2) cycle(0, 1, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin : stim
    bit nc, ec, pr, pe, tk, rs;
    int guard;

    // Idle: NS green rests indefinitely.
    do_reset();
    repeat (100) cycle(1, 1, 0, 0, 0, 0, 0, 0);

    // EW demand only: minimum NS green, then EW rests.
    do_reset();
    repeat (40) cycle(1, 1, 0, 1, 0, 0, 0, 0);

    // Both sides demanding: max-green cycling.
    do_reset();
    repeat (120) cycle(1, 1, 1, 1, 0, 0, 0, 0);

    // EW pedestrian pulse during NS green brings a served EW green with walk.
    do_reset();
    repeat (3) cycle(1, 1, 0, 0, 0, 0, 0, 0);
    cycle(1, 1, 0, 0, 0, 1, 0, 0);
    repeat (30) cycle(1, 1, 0, 0, 0, 0, 0, 0);
    // Pedestrian requests coinciding with green entries and during own green.
    cycle(1, 1, 0, 0, 1, 0, 0, 0);
    repeat (20) cycle(1, 1, 0, 0, 0, 0, 0, 0);

    // Preemption toward NS while EW green with elapsed 1.
    do_reset();
    guard = 0;
    while (!(m_ph == 4 && m_t == 1) && guard < 100) begin
      cycle(1, 1, 0, 1, 0, 0, 0, 0);
      guard++;
    end
    checks++;
    if (guard >= 100) begin
      errors++;
      $display("FAIL preempt_setup got guard=%0d required <100", guard);
    end
    repeat (30) cycle(1, 1, 1, 1, 0, 0, 1, 0);
    repeat (40) cycle(1, 1, 1, 1, 0, 0, 0, 0);
    // Preempt toward EW during all-red/yellow transitions.
    repeat (15) cycle(1, 1, 1, 1, 0, 0, 1, 1);
    repeat (10) cycle(1, 1, 1, 1, 0, 0, 0, 0);

    // Reset mid-yellow, then tick stalls everything.
    do_reset();
    guard = 0;
    while (m_ph != 2 && guard < 100) begin
      cycle(1, 1, 0, 1, 0, 0, 0, 0);
      guard++;
    end
    cycle(1, 1, 0, 1, 0, 0, 0, 0);
    cycle(0, 1, 0, 1, 0, 0, 0, 0);
    repeat (10) cycle(1, 0, 1, 1, 1, 1, 0, 0);
    repeat (30) cycle(1, 1, 1, 1, 0, 0, 0, 0);

    // Randomized traffic.
    do_reset();
    nc = 0; ec = 0; pr = 0; pe = 0;
    repeat (4000) begin
      if ($urandom_range(19) == 0) nc = ~nc;
      if ($urandom_range(19) == 0) ec = ~ec;
      if ($urandom_range(149) == 0) begin
        pr = ~pr;
        pe = 1'($urandom_range(1));
      end
      tk = ($urandom_range(3) != 0);
      rs = ($urandom_range(399) != 0);
      cycle(rs, tk, nc, ec, ($urandom_range(24) == 0), ($urandom_range(24) == 0), pr, pe);
    end

    guard = 0;
    while (exp_q.size() > 0 && guard < 10) begin
      @(posedge clk);
      guard++;
    end
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain got pending=%0d required 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
